// File: rtl/lcd_frame_scheduler.sv
// -----------------------------------------------------------------------------
// lcd_frame_scheduler
// -----------------------------------------------------------------------------
// Timing controller for the 480x272 TFT-LCD pong display.
//
// A horizontal pixel counter is cascaded into a vertical line counter. Both are
// decoded into sync / active flags. Those flags drive registered hsync, vsync,
// de and the active-pixel coordinates, one clock after the counters.
// The controller also owns the update window used by game logic. A request is
// granted only during vertical blanking. If the game logic has not finished
// when the first active line starts, the grant is revoked and flagged.
//
// Ports
//   clk             pixel clock
//   nrst            asynchronous active-low reset
//   i_run           level: 1 = scan, 0 = stop at the end of the current frame
//   o_hsync         horizontal sync (low for h_cnt 0..H_SYNC)
//   o_vsync         vertical sync (low for v_cnt 0..V_SYNC)
//   o_de            data enable, high only when both axes are active
//   o_px_x/o_px_y   active pixel column/row, 0 while o_de is low
//   o_frame_start   one-cycle pulse when a frame starts (h_cnt=0, v_cnt=0)
//   o_frame_cnt     frames started since reset, wraps
//   i_upd_req       game logic requests the update window (level)
//   i_upd_done      one-cycle pulse, game logic finished its update
//   o_upd_gnt       update window granted
//   o_upd_ovr       one-cycle pulse, grant revoked before i_upd_done
//   o_busy          1 while the display is being scanned (RUN or DRAIN)
// -----------------------------------------------------------------------------
module lcd_frame_scheduler #(
    parameter int unsigned H_SYNC  = 40,
    parameter int unsigned H_EN    = 2,
    parameter int unsigned H_COUNT = 524,
    parameter int unsigned V_SYNC  = 10,
    parameter int unsigned V_EN    = 2,
    parameter int unsigned V_COUNT = 286
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_run,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [9:0]  o_px_x,
    output logic [9:0]  o_px_y,
    output logic        o_frame_start,
    output logic [15:0] o_frame_cnt,
    input  logic        i_upd_req,
    input  logic        i_upd_done,
    output logic        o_upd_gnt,
    output logic        o_upd_ovr,
    output logic        o_busy
);

    // Axis timing constants, narrowed to the counter width.
    localparam logic [9:0] H_S    = 10'(H_SYNC);
    localparam logic [9:0] H_E    = 10'(H_EN);
    localparam logic [9:0] H_N    = 10'(H_COUNT);
    localparam logic [9:0] V_S    = 10'(V_SYNC);
    localparam logic [9:0] V_E    = 10'(V_EN);
    localparam logic [9:0] V_N    = 10'(V_COUNT);
    // First active counter value on each axis; also the coordinate origin.
    localparam logic [9:0] H_ACT0 = 10'(H_SYNC + H_EN + 1);
    localparam logic [9:0] V_ACT0 = 10'(V_SYNC + V_EN + 1);

    // Scan state machine encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Decode one axis counter into {sync, active}.
    //   c <= s          : sync low, inactive
    //   s < c <= s+e    : sync high, porch
    //   s+e < c <= n-e  : sync high, active
    //   n-e < c <= n    : sync high, porch
    function automatic logic [1:0] axis_decode(
        input logic [9:0] c,
        input logic [9:0] s,
        input logic [9:0] e,
        input logic [9:0] n
    );
        logic sync_v;
        logic act_v;
        sync_v = (c > s);
        act_v  = (c > (s + e)) && (c <= (n - e));
        return {sync_v, act_v};
    endfunction

    logic [1:0]  r_state;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic [9:0]  r_px_x;
    logic [9:0]  r_px_y;
    logic        r_frame_start;
    logic [15:0] r_frame_cnt;
    logic        r_upd_gnt;
    logic        r_upd_ovr;
    logic        r_upd_lock;
    logic        r_busy;

    logic [1:0]  w_state_nxt;
    logic [9:0]  w_h_nxt;
    logic [9:0]  w_v_nxt;
    logic [1:0]  w_h_dec;
    logic [1:0]  w_v_dec;
    logic        w_scan;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_frame_end;
    logic        w_de;
    logic        w_frame_first;
    logic        w_vblank;
    logic        w_win_close;

    assign w_scan        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_h_last      = (r_h_cnt == H_N);
    assign w_v_last      = (r_v_cnt == V_N);
    assign w_frame_end   = w_h_last && w_v_last;
    assign w_h_dec       = axis_decode(r_h_cnt, H_S, H_E, H_N);
    assign w_v_dec       = axis_decode(r_v_cnt, V_S, V_E, V_N);
    assign w_de          = w_scan && w_h_dec[0] && w_v_dec[0];
    assign w_frame_first = w_scan && (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
    // Blanking covers idle time and every line outside the active rows.
    assign w_vblank      = !w_scan || !w_v_dec[0];
    // The update window closes at the start of the first active line.
    assign w_win_close   = w_scan && (r_v_cnt == V_ACT0) && (r_h_cnt == 10'd0);

    // Scan state transitions. A stop request only ends scanning on the last
    // cycle of a frame, so the display always receives whole frames.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_run) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!i_run && w_frame_end) begin
                    w_state_nxt = ST_IDLE;
                end else if (!i_run) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (i_run) begin
                    w_state_nxt = ST_RUN;
                end else if (w_frame_end) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next counter values: cascaded wrap while scanning, parked at 0 otherwise.
    always_comb begin
        w_h_nxt = r_h_cnt;
        w_v_nxt = r_v_cnt;
        if (w_scan && (w_state_nxt != ST_IDLE)) begin
            if (w_h_last) begin
                w_h_nxt = 10'd0;
                if (w_v_last) begin
                    w_v_nxt = 10'd0;
                end else begin
                    w_v_nxt = r_v_cnt + 10'd1;
                end
            end else begin
                w_h_nxt = r_h_cnt + 10'd1;
                w_v_nxt = r_v_cnt;
            end
        end else begin
            w_h_nxt = 10'd0;
            w_v_nxt = 10'd0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Video outputs, registered one clock behind the counters.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_de          <= 1'b0;
            r_px_x        <= 10'd0;
            r_px_y        <= 10'd0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= 16'd0;
        end else begin
            r_hsync       <= w_scan && w_h_dec[1];
            r_vsync       <= w_scan && w_v_dec[1];
            r_de          <= w_de;
            r_px_x        <= w_de ? (r_h_cnt - H_ACT0) : 10'd0;
            r_px_y        <= w_de ? (r_v_cnt - V_ACT0) : 10'd0;
            r_frame_start <= w_frame_first;
            if (w_frame_first) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
        end
    end

    // Update-window arbitration. r_upd_lock blocks a second grant within the
    // same blanking period after any drop; it clears once active video starts.
    // A completion pulse takes priority over a simultaneous window close.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_upd_gnt  <= 1'b0;
            r_upd_ovr  <= 1'b0;
            r_upd_lock <= 1'b0;
        end else begin
            r_upd_ovr <= 1'b0;
            if (r_upd_gnt) begin
                if (i_upd_done) begin
                    r_upd_gnt  <= 1'b0;
                    r_upd_lock <= 1'b1;
                end else if (w_win_close) begin
                    r_upd_gnt  <= 1'b0;
                    r_upd_ovr  <= 1'b1;
                    r_upd_lock <= 1'b1;
                end else begin
                    r_upd_gnt  <= 1'b1;
                end
            end else if (i_upd_req && w_vblank && !r_upd_lock) begin
                r_upd_gnt <= 1'b1;
            end else if (!w_vblank) begin
                r_upd_lock <= 1'b0;
            end else begin
                r_upd_lock <= r_upd_lock;
            end
        end
    end

    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_de          = r_de;
    assign o_px_x        = r_px_x;
    assign o_px_y        = r_px_y;
    assign o_frame_start = r_frame_start;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_upd_gnt     = r_upd_gnt;
    assign o_upd_ovr     = r_upd_ovr;
    assign o_busy        = r_busy;

endmodule
